// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule: S-box, sub_word, xtime,
// the round-key type and the key-schedule FSM encoding.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: derives round key n from round key n-1
// and the round constant. Purely combinational.
module aes_key_round
  import aes_pkg::*;
(
  input  round_key_t  key_prev,
  input  logic [7:0]  rcon,
  output round_key_t  key_next
);

  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic [31:0] t_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;

  assign w0_s = key_prev[127:96];
  assign w1_s = key_prev[95:64];
  assign w2_s = key_prev[63:32];
  assign w3_s = key_prev[31:0];

  // RotWord moves the top byte to the bottom before substitution.
  assign t_s  = sub_word({w3_s[23:0], w3_s[31:24]}) ^ {rcon, 24'h000000};

  assign n0_s = w0_s ^ t_s;
  assign n1_s = w1_s ^ n0_s;
  assign n2_s = w2_s ^ n1_s;
  assign n3_s = w3_s ^ n2_s;

  assign key_next = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: expands one cipher key at one round per
// cycle into an eleven-entry round-key register file with a registered read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_out,
  output logic         keys_ready,
  output logic         busy
);

  localparam logic [3:0] NR_C = 4'(NR);

  ks_state_t   state_r;
  logic [3:0]  cnt_r;
  logic [7:0]  rcon_r;
  round_key_t  rk_r [NR+1];
  logic        key_ready_r;
  logic        keys_ready_r;
  logic        busy_r;
  round_key_t  rk_out_r;

  logic        accept_s;
  round_key_t  prev_key_s;
  round_key_t  next_key_s;
  round_key_t  rd_data_s;

  assign accept_s = key_valid && key_ready_r && (state_r != EXPAND);

  // Select the key feeding the shared round unit.
  always_comb begin
    prev_key_s = '0;
    if ((cnt_r != 4'd0) && (cnt_r <= NR_C)) begin
      prev_key_s = rk_r[cnt_r - 4'd1];
    end else begin
      prev_key_s = '0;
    end
  end

  aes_key_round u_round (
    .key_prev (prev_key_s),
    .rcon     (rcon_r),
    .key_next (next_key_s)
  );

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      rcon_r       <= 8'h00;
      key_ready_r  <= 1'b0;
      keys_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            state_r      <= EXPAND;
            cnt_r        <= 4'd1;
            rcon_r       <= 8'h01;
            key_ready_r  <= 1'b0;
            keys_ready_r <= 1'b0;
            busy_r       <= 1'b1;
          end else begin
            key_ready_r  <= 1'b1;
            keys_ready_r <= (state_r == DONE);
            busy_r       <= 1'b0;
          end
        end
        EXPAND: begin
          cnt_r  <= cnt_r + 4'd1;
          rcon_r <= xtime(rcon_r);
          if (cnt_r == NR_C) begin
            state_r      <= DONE;
            key_ready_r  <= 1'b1;
            keys_ready_r <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            state_r <= EXPAND;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= 4'd0;
          rcon_r       <= 8'h00;
          key_ready_r  <= 1'b0;
          keys_ready_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  // Round-key register file: entry 0 loads on accept, entry cnt on each round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= NR; i++) begin
        rk_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (accept_s && (i == 0)) begin
          rk_r[i] <= key_in;
        end else if ((state_r == EXPAND) && (cnt_r == 4'(i))) begin
          rk_r[i] <= next_key_s;
        end else begin
          rk_r[i] <= rk_r[i];
        end
      end
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    rd_data_s = '0;
    if (rk_addr <= NR_C) begin
      rd_data_s = rk_r[rk_addr];
    end else begin
      rd_data_s = '0;
    end
  end

  // Registered read port; sees the pre-write value on a same-cycle write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk_out_r <= '0;
    end else begin
      rk_out_r <= rd_data_s;
    end
  end

  assign key_ready  = key_ready_r;
  assign keys_ready = keys_ready_r;
  assign busy       = busy_r;
  assign rk_out     = rk_out_r;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule; round-key reads are checked through a
// scoreboard queue against an independently built key-expansion model.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;
  logic         keys_ready;
  logic         busy;

  int tests = 0;
  int fails = 0;

  logic [127:0] exp_q [$];
  string        tag_q [$];
  logic [7:0]   sbox_m [256];
  logic [127:0] mk [11];

  localparam logic [7:0]   RCON_T [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_TWO  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] KEY_BP   = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_addr    (rk_addr),
    .rk_out     (rk_out),
    .keys_ready (keys_ready),
    .busy       (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from the GF(2^8) inverse followed by the affine transform.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] bb  = 8'(b);
      if (b != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(bb, 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w [4];
    logic [31:0] r, t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    r = {w[3][23:0], w[3][31:24]};
    t = {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]} ^ {rc, 24'h000000};
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic model_expand(input logic [127:0] k);
    mk[0] = k;
    for (int n = 1; n <= 10; n++) mk[n] = model_round(mk[n-1], RCON_T[n-1]);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_push(input logic [3:0] addr, input logic [127:0] expv, input string tag);
    rk_addr = addr;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic read_pop();
    logic [127:0] e;
    string t;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, rk_out, e);
    end
  endtask

  // Called just after the accept edge; ends just after the cycle-10 edge.
  task automatic run_expansion(input string tag);
    check({tag, "_busy_after_accept"}, 128'(busy), 128'd1);
    check({tag, "_keys_ready_drop"}, 128'(keys_ready), 128'd0);
    for (int n = 1; n <= 10; n++) begin
      check($sformatf("%s_rcon_r%0d", tag, n), 128'(dut.rcon_r), 128'(RCON_T[n-1]));
      check($sformatf("%s_busy_c%0d", tag, n), 128'(busy), 128'd1);
      check($sformatf("%s_key_ready_c%0d", tag, n), 128'(key_ready), 128'd0);
      check($sformatf("%s_keys_ready_c%0d", tag, n), 128'(keys_ready), 128'd0);
      tick();
    end
    check({tag, "_keys_ready_done"}, 128'(keys_ready), 128'd1);
    check({tag, "_key_ready_done"}, 128'(key_ready), 128'd1);
    check({tag, "_busy_done"}, 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] a_rk10;
    rst       = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rk_addr   = 4'd0;
    build_sbox();

    // Reset values.
    #2;
    check("rst_key_ready", 128'(key_ready), 128'd0);
    check("rst_keys_ready", 128'(keys_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rk_out", rk_out, 128'd0);
    tick();
    tick();
    check("rst_key_ready_held", 128'(key_ready), 128'd0);
    rst = 1'b1;
    tick();
    check("post_rst_key_ready", 128'(key_ready), 128'd1);

    // FIPS-197 key, single-cycle valid.
    model_expand(KEY_FIPS);
    key_in = KEY_FIPS;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    run_expansion("fips");
    read_push(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
    tick(); read_pop();
    read_push(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
    tick(); read_pop();
    read_push(4'd0, KEY_FIPS, "fips_rk0");
    tick(); read_pop();
    read_push(4'd11, 128'd0, "addr11_zero");
    tick(); read_pop();
    read_push(4'd15, 128'd0, "addr15_zero");
    tick(); read_pop();
    for (int i = 0; i <= 10; i++) begin
      read_push(4'(i), mk[i], $sformatf("sweep_rk%0d", i));
      tick();
      read_pop();
    end

    // Second key accepted from DONE.
    model_expand(KEY_TWO);
    key_in = KEY_TWO;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    run_expansion("two");
    read_push(4'd1, 128'hb6315b6d9871c4fb714cbaea02dfadc0, "two_rk1");
    tick(); read_pop();
    read_push(4'd10, mk[10], "two_rk10");
    tick(); read_pop();

    // Backpressure: a different key held valid throughout expansion.
    model_expand(KEY_FIPS);
    a_rk10 = mk[10];
    key_in = KEY_FIPS;
    key_valid = 1'b1;
    tick();
    key_in = KEY_BP;
    run_expansion("bp_first");
    read_push(4'd10, a_rk10, "bp_first_rk10_kept");
    tick();
    key_valid = 1'b0;
    read_pop();
    model_expand(KEY_BP);
    run_expansion("bp_second");
    read_push(4'd10, mk[10], "bp_rk10");
    tick(); read_pop();
    read_push(4'd0, KEY_BP, "bp_rk0");
    tick(); read_pop();

    // Reset asserted at cycle 5 of an expansion.
    key_in = KEY_FIPS;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    #1;
    check("midrst_key_ready", 128'(key_ready), 128'd0);
    check("midrst_keys_ready", 128'(keys_ready), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_rk_out", rk_out, 128'd0);
    check("midrst_rcon", 128'(dut.rcon_r), 128'd0);
    tick();
    rst = 1'b1;
    read_push(4'd10, 128'd0, "midrst_rk10_cleared");
    tick(); read_pop();
    check("midrst_key_ready_back", 128'(key_ready), 128'd1);
    key_in = KEY_FIPS;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    run_expansion("after_rst");
    read_push(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "after_rst_rk10");
    tick(); read_pop();
    read_push(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "after_rst_rk1");
    tick(); read_pop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
